// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencing the shared multicycle MIPS datapath
//
// Purpose: steps R-type, LW, SW, BEQ, ADDI and J through the shared
//   memory/ALU datapath. It issues per-state strobes and mux selects. Memory
//   states stall on mem_ready, and the FSM traps to ERROR when memory stays
//   not-ready for TIMEOUT_CYCLES cycles in a row.
// Parameters:
//   MEM_HANDSHAKE   1: memory states wait for mem_ready; 0: always ready
//   TIMEOUT_CYCLES  consecutive not-ready cycles tolerated; 0 disables the trap
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   opcode[5:0]                  instr[31:26] from IR
//   mem_ready                    memory completes its access this cycle
//   pc_write, branch, ir_write   PC / IR load strobes
//   iord, mem_write              memory address select, write enable
//   mem_to_reg, reg_write, reg_dst  register-file write controls
//   alu_src_a, alu_src_b[1:0]    ALU operand selects
//   pc_src[1:0], alu_op[1:0]     PC source select, ALU operation class
//   instr_done                   pulse in the last state of an instruction
//   err_timeout                  high while in ERROR
//   state[3:0]                   current state code
module multicycle_ctrl #(
    parameter int MEM_HANDSHAKE  = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       err_timeout,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // The counter must be able to hold TIMEOUT_CYCLES: it increments once
    // more on the cycle that enters ERROR.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_ready;
    logic            w_mem_state;
    logic            w_next_mem;
    logic            w_timeout;

    logic       w_pc_write, w_branch, w_ir_write, w_iord, w_mem_write;
    logic       w_mem_to_reg, w_reg_write, w_reg_dst, w_alu_src_a;
    logic       w_instr_done, w_err_timeout;
    logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;

    assign w_ready     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_next_mem  = (w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR);
    // A ready cycle always wins over the timeout: the states below test
    // w_ready before they test w_timeout.
    assign w_timeout   = (TIMEOUT_CYCLES > 0) && w_mem_state && !w_ready
                         && (r_wait_cnt == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) && w_next_mem) begin
                r_wait_cnt <= '0;
            end else if (w_mem_state) begin
                r_wait_cnt <= w_ready ? '0 : r_wait_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        w_ir_write    = 1'b0;
        w_iord        = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_pc_src      = 2'b00;
        w_alu_op      = 2'b00;
        w_instr_done  = 1'b0;
        w_err_timeout = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b = 2'b01;
                // The IR and PC load only when the fetch actually returns data.
                w_ir_write  = w_ready;
                w_pc_write  = w_ready;
                if (w_ready)        w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_EXEC;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (w_ready)        w_next = S_MEMWB;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = w_ready;
                if (w_ready)        w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
                w_pc_src     = 2'b01;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = 2'b10;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ERROR: begin
                w_err_timeout = 1'b1;
                w_next        = S_ERROR;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // While reset is held, no strobe may reach the datapath. The state
    // output already reads FETCH, even before the reset edge lands.
    assign pc_write    = w_pc_write    & ~reset;
    assign branch      = w_branch      & ~reset;
    assign ir_write    = w_ir_write    & ~reset;
    assign iord        = w_iord        & ~reset;
    assign mem_write   = w_mem_write   & ~reset;
    assign mem_to_reg  = w_mem_to_reg  & ~reset;
    assign reg_write   = w_reg_write   & ~reset;
    assign reg_dst     = w_reg_dst     & ~reset;
    assign alu_src_a   = w_alu_src_a   & ~reset;
    assign alu_src_b   = w_alu_src_b   & {2{~reset}};
    assign pc_src      = w_pc_src      & {2{~reset}};
    assign alu_op      = w_alu_op      & {2{~reset}};
    assign instr_done  = w_instr_done  & ~reset;
    assign err_timeout = w_err_timeout & ~reset;
    assign state       = reset ? S_FETCH : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = OP_RTYPE;
    logic       mem_ready = 1'b1;
    logic       pc_write, branch, ir_write, iord, mem_write, mem_to_reg;
    logic       reg_write, reg_dst, alu_src_a, instr_done, err_timeout;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;
    exp_t sb_q[$];

    multicycle_ctrl #(.MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .iord(iord),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_op(alu_op), .instr_done(instr_done),
        .err_timeout(err_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected control word for a state, following the per-state table.
    function automatic logic [16:0] exp_ctl(input logic rst, input logic [3:0] st, input logic rdy);
        logic pcw, br, irw, ird, mw, m2r, rw, rd, asa, done, err;
        logic [1:0] asb, pcs, aop;
        {pcw, br, irw, ird, mw, m2r, rw, rd, asa, done, err} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        if (!rst) begin
            case (st)
                4'd0:  begin asb = 2'b01; irw = rdy; pcw = rdy; end
                4'd1:  asb = 2'b11;
                4'd2:  begin asa = 1'b1; asb = 2'b10; end
                4'd3:  ird = 1'b1;
                4'd4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
                4'd5:  begin ird = 1'b1; mw = 1'b1; done = rdy; end
                4'd6:  begin asa = 1'b1; aop = 2'b10; end
                4'd7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
                4'd8:  begin asa = 1'b1; aop = 2'b01; br = 1'b1; pcs = 2'b01; done = 1'b1; end
                4'd9:  begin asa = 1'b1; asb = 2'b10; end
                4'd10: begin rw = 1'b1; done = 1'b1; end
                4'd11: begin pcw = 1'b1; pcs = 2'b10; done = 1'b1; end
                4'd12: err = 1'b1;
                default: ;
            endcase
        end
        return {pcw, br, irw, ird, mw, m2r, rw, rd, asa, asb, pcs, aop, done, err};
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs, compare on the falling edge.
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy, input logic [3:0] st);
        exp_t e;
        logic [16:0] obs;
        reset = rst;
        opcode = op;
        mem_ready = rdy;
        e.st  = rst ? 4'd0 : st;
        e.ctl = exp_ctl(rst, e.st, rdy);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        obs = {pc_write, branch, ir_write, iord, mem_write, mem_to_reg, reg_write, reg_dst,
               alu_src_a, alu_src_b, pc_src, alu_op, instr_done, err_timeout};
        check_eq($sformatf("cyc%0d_state", cyc), {28'd0, state}, {28'd0, e.st});
        check_eq($sformatf("cyc%0d_ctl_s%0d", cyc, e.st), {15'd0, obs}, {15'd0, e.ctl});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset, then R-type: 0,1,6,7
        repeat (3) step(1'b1, OP_RTYPE, 1'b1, 4'd0);
        step(0, OP_RTYPE, 1, 0); step(0, OP_RTYPE, 1, 1); step(0, OP_RTYPE, 1, 6); step(0, OP_RTYPE, 1, 7);
        // LW: 0,1,2,3,4
        step(0, OP_LW, 1, 0); step(0, OP_LW, 1, 1); step(0, OP_LW, 1, 2); step(0, OP_LW, 1, 3); step(0, OP_LW, 1, 4);
        // SW: 0,1,2,5
        step(0, OP_SW, 1, 0); step(0, OP_SW, 1, 1); step(0, OP_SW, 1, 2); step(0, OP_SW, 1, 5);
        // BEQ: 0,1,8
        step(0, OP_BEQ, 1, 0); step(0, OP_BEQ, 1, 1); step(0, OP_BEQ, 1, 8);
        // J: 0,1,11
        step(0, OP_J, 1, 0); step(0, OP_J, 1, 1); step(0, OP_J, 1, 11);
        // ADDI: 0,1,9,10
        step(0, OP_ADDI, 1, 0); step(0, OP_ADDI, 1, 1); step(0, OP_ADDI, 1, 9); step(0, OP_ADDI, 1, 10);
        // SW with three not-ready cycles in MEMWR: mem_write held four cycles
        step(0, OP_SW, 1, 0); step(0, OP_SW, 1, 1); step(0, OP_SW, 1, 2);
        step(0, OP_SW, 0, 5); step(0, OP_SW, 0, 5); step(0, OP_SW, 0, 5); step(0, OP_SW, 1, 5);
        // FETCH waits three cycles; ready on the 4th wins over the timeout
        step(0, OP_BAD, 0, 0); step(0, OP_BAD, 0, 0); step(0, OP_BAD, 0, 0); step(0, OP_BAD, 1, 0);
        // Unknown opcode decodes as R-type
        step(0, OP_BAD, 1, 1); step(0, OP_BAD, 1, 6); step(0, OP_BAD, 1, 7);
        // LW with MEMRD stuck not-ready: the 4th not-ready cycle is the last before ERROR
        step(0, OP_LW, 1, 0); step(0, OP_LW, 1, 1); step(0, OP_LW, 1, 2);
        step(0, OP_LW, 0, 3); step(0, OP_LW, 0, 3); step(0, OP_LW, 0, 3); step(0, OP_LW, 0, 3);
        step(0, OP_LW, 1, 12); step(0, OP_LW, 1, 12);
        step(1, OP_LW, 1, 0);
        // FETCH stuck not-ready: ERROR after four cycles, then stays until reset
        step(0, OP_RTYPE, 0, 0); step(0, OP_RTYPE, 0, 0); step(0, OP_RTYPE, 0, 0); step(0, OP_RTYPE, 0, 0);
        step(0, OP_RTYPE, 0, 12); step(0, OP_RTYPE, 1, 12); step(0, OP_RTYPE, 1, 12);
        step(1, OP_RTYPE, 1, 0);
        step(0, OP_RTYPE, 1, 0); step(0, OP_RTYPE, 1, 1); step(0, OP_RTYPE, 1, 6); step(0, OP_RTYPE, 1, 7);
        // Reset in MEMRD abandons the load; strobes are zero during reset
        step(0, OP_LW, 1, 0); step(0, OP_LW, 1, 1); step(0, OP_LW, 1, 2);
        step(1, OP_LW, 1, 0);
        step(0, OP_LW, 1, 0); step(0, OP_LW, 1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
